// File: rtl/subservient_dbg_pkg.sv
// subservient_dbg_pkg
//   Shared definitions for the subservient debug host:
//   command opcodes, response codes, the FSM state type and small
//   helper functions used to decode opcodes.
//   Optional feature macro used by the host: SUBSERVIENT_DBG_TIMEOUT_EN.
package subservient_dbg_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] OP_WR  = 8'h57;  // 'W' + adr[4] + dat[4]
  localparam logic [7:0] OP_RD  = 8'h52;  // 'R' + adr[4]
  localparam logic [7:0] OP_DBG = 8'h44;  // 'D' + 1 byte

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_TMO = 8'hEE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARGS = 2'd1,
    BUS  = 2'd2,
    RESP = 2'd3
  } state_e;

  // Opcode is one the host knows how to execute.
  function automatic logic op_known(input logic [7:0] op);
    logic known;
    case (op)
      OP_WR, OP_RD, OP_DBG: known = 1'b1;
      default:              known = 1'b0;
    endcase
    return known;
  endfunction

  // Index of the last argument byte for an opcode (8, 4 or 1 bytes).
  function automatic logic [2:0] args_last(input logic [7:0] op);
    logic [2:0] last;
    case (op)
      OP_WR:   last = 3'd7;
      OP_RD:   last = 3'd3;
      default: last = 3'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/subservient_dbg_host_resp.sv
// subservient_dbg_resp
//   Response serializer. A load captures a 32-bit word and a length flag
//   (1 byte or 4 bytes); bytes leave LSB first on a valid/ready stream.
//   o_done pulses for one cycle after the last byte handshake.
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           load i_word/i_four (valid rises on the next cycle)
//   i_word           word to send
//   i_four           1: send four bytes, 0: send only i_word[7:0]
//   o_data/o_valid   response byte stream
//   i_ready          downstream ready
//   o_done           one-cycle pulse after the final byte was consumed
module subservient_dbg_resp
  import subservient_dbg_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_four,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_done
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [1:0]        left_q, left_d;   // bytes remaining after the current one
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  // Next-state logic for the shift register and handshake tracking.
  always_comb begin
    shreg_d = shreg_q;
    left_d  = left_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (i_load) begin
      shreg_d = i_word;
      left_d  = i_four ? 2'd3 : 2'd0;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      if (left_q == 2'd0) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        shreg_d = {8'h00, shreg_q[WORD_W-1:8]};
        left_d  = left_q - 2'd1;
      end
    end else begin
      shreg_d = shreg_q;
      left_d  = left_q;
    end
  end

  // Serializer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q <= {WORD_W{1'b0}};
      left_q  <= 2'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = shreg_q[7:0];
  assign o_valid = valid_q;
  assign o_done  = done_q;

endmodule

// File: rtl/subservient_dbg_host.sv
// subservient_dbg_host
//   Byte-stream to Wishbone debug initiator for the subservient core.
//   Commands (little-endian fields):
//     'W' adr[4] dat[4] -> 32-bit write, reply 0x06
//     'R' adr[4]        -> 32-bit read, reply rdt LSB first
//     'D' b             -> debug_mode <= b[0], reply 0x06
//     other             -> reply 0x15, no argument bytes consumed
//   W/R while debug_mode=0 consume their payload and reply 0x15 without
//   touching the bus.
//   Optional feature: define SUBSERVIENT_DBG_TIMEOUT_EN to abort a bus
//   access after TIMEOUT cycles without ack (reply 0xEE).
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_rx_data/valid, o_rx_ready   command byte stream in
//   o_tx_data/valid, i_tx_ready   response byte stream out
//   o_debug_mode               to core i_debug_mode
//   o_wb_dbg_*                 Wishbone initiator outputs (classic, single beat)
//   i_wb_dbg_rdt, i_wb_dbg_ack Wishbone read data and acknowledge
module subservient_dbg_host
  import subservient_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic [31:0] i_wb_dbg_rdt,
  input  logic        i_wb_dbg_ack
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        stb_q, stb_d;
  logic [3:0]  sel_q, sel_d;
  logic        dbg_q, dbg_d;
  logic        rx_ready_q, rx_ready_d;
  logic [31:0] rsp_word_q, rsp_word_d;
  logic        rsp_four_q, rsp_four_d;
  logic        rsp_started_q, rsp_started_d;

  logic        rx_accept_s;
  logic        args_done_s;
  logic        rsp_load_s;
  logic        rsp_done_s;
  logic        tmo_hit_s;

  assign rx_accept_s = i_rx_valid && rx_ready_q;
  assign args_done_s = rx_accept_s && (cnt_q == args_last(op_q));
  // Load the serializer in the first RESP cycle so valid rises one cycle later.
  assign rsp_load_s  = (state_q == RESP) && !rsp_started_q;

`ifdef SUBSERVIENT_DBG_TIMEOUT_EN
  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Fires in the last allowed strobe cycle so stb is high exactly TIMEOUT cycles.
  assign tmo_hit_s = stb_q && (tmo_cnt_q == TO_W'(TIMEOUT - 1));

  // Strobe-age counter; held at zero outside BUS so it starts cleared.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != BUS) begin
      tmo_cnt_d = {TO_W{1'b0}};
    end else if (stb_q) begin
      tmo_cnt_d = tmo_cnt_q + TO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= {TO_W{1'b0}};
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [TO_W-1:0] unused_timeout_s;

  assign tmo_hit_s        = 1'b0;
  assign unused_timeout_s = TO_W'(TIMEOUT);
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_accept_s) begin
          state_d = op_known(i_rx_data) ? ARGS : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      ARGS: begin
        if (args_done_s) begin
          if (op_q == OP_DBG) begin
            state_d = RESP;
          end else if (dbg_q) begin
            state_d = BUS;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = ARGS;
        end
      end
      BUS: begin
        if (i_wb_dbg_ack || tmo_hit_s) begin
          state_d = RESP;
        end else begin
          state_d = BUS;
        end
      end
      RESP: begin
        if (rsp_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values per state.
  always_comb begin
    op_d          = op_q;
    cnt_d         = cnt_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    we_d          = we_q;
    stb_d         = stb_q;
    sel_d         = sel_q;
    dbg_d         = dbg_q;
    rsp_word_d    = rsp_word_q;
    rsp_four_d    = rsp_four_q;
    rsp_started_d = rsp_started_q;
    rx_ready_d    = (state_d == IDLE) || (state_d == ARGS);
    case (state_q)
      IDLE: begin
        if (rx_accept_s) begin
          op_d  = i_rx_data;
          cnt_d = 3'd0;
          if (!op_known(i_rx_data)) begin
            rsp_word_d = {24'h000000, RSP_NAK};
            rsp_four_d = 1'b0;
          end else begin
            rsp_word_d = rsp_word_q;
          end
        end else begin
          op_d = op_q;
        end
      end
      ARGS: begin
        if (rx_accept_s) begin
          cnt_d = cnt_q + 3'd1;
          // Bytes 0-3 fill the address, 4-7 the write data.
          if (op_q == OP_DBG) begin
            dbg_d = i_rx_data[0];
          end else if (cnt_q[2]) begin
            dat_d[{cnt_q[1:0], 3'b000} +: 8] = i_rx_data;
          end else begin
            adr_d[{cnt_q[1:0], 3'b000} +: 8] = i_rx_data;
          end
          if (args_done_s) begin
            rsp_four_d = 1'b0;
            if (op_q == OP_DBG) begin
              rsp_word_d = {24'h000000, RSP_ACK};
            end else if (dbg_q) begin
              stb_d = 1'b1;
              we_d  = (op_q == OP_WR);
              sel_d = 4'hF;
            end else begin
              rsp_word_d = {24'h000000, RSP_NAK};
            end
          end else begin
            rsp_four_d = rsp_four_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUS: begin
        if (i_wb_dbg_ack) begin
          stb_d      = 1'b0;
          rsp_word_d = we_q ? {24'h000000, RSP_ACK} : i_wb_dbg_rdt;
          rsp_four_d = !we_q;
        end else if (tmo_hit_s) begin
          stb_d      = 1'b0;
          rsp_word_d = {24'h000000, RSP_TMO};
          rsp_four_d = 1'b0;
        end else begin
          stb_d = stb_q;
        end
      end
      RESP: begin
        if (rsp_done_s) begin
          rsp_started_d = 1'b0;
        end else if (rsp_load_s) begin
          rsp_started_d = 1'b1;
        end else begin
          rsp_started_d = rsp_started_q;
        end
      end
      default: begin
        stb_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q          <= 8'h00;
      cnt_q         <= 3'd0;
      adr_q         <= 32'h00000000;
      dat_q         <= 32'h00000000;
      we_q          <= 1'b0;
      stb_q         <= 1'b0;
      sel_q         <= 4'h0;
      dbg_q         <= 1'b0;
      rx_ready_q    <= 1'b0;
      rsp_word_q    <= 32'h00000000;
      rsp_four_q    <= 1'b0;
      rsp_started_q <= 1'b0;
    end else begin
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      we_q          <= we_d;
      stb_q         <= stb_d;
      sel_q         <= sel_d;
      dbg_q         <= dbg_d;
      rx_ready_q    <= rx_ready_d;
      rsp_word_q    <= rsp_word_d;
      rsp_four_q    <= rsp_four_d;
      rsp_started_q <= rsp_started_d;
    end
  end

  subservient_dbg_resp u_resp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (rsp_load_s),
    .i_word  (rsp_word_q),
    .i_four  (rsp_four_q),
    .o_data  (o_tx_data),
    .o_valid (o_tx_valid),
    .i_ready (i_tx_ready),
    .o_done  (rsp_done_s)
  );

  assign o_rx_ready   = rx_ready_q;
  assign o_debug_mode = dbg_q;
  assign o_wb_dbg_adr = adr_q;
  assign o_wb_dbg_dat = dat_q;
  assign o_wb_dbg_sel = sel_q;
  assign o_wb_dbg_we  = we_q;
  assign o_wb_dbg_stb = stb_q;

endmodule

// File: tb/tb_subservient_dbg_host.sv
// tb_subservient_dbg_host
//   Directed and randomized checks of the debug host against a
//   command-level reference model (expected reply bytes and bus
//   transactions derived from the command semantics).
//   Build with SUBSERVIENT_DBG_TIMEOUT_EN to exercise the timeout path.
module tb_subservient_dbg_host;

  localparam logic [7:0] C_WR  = 8'h57;
  localparam logic [7:0] C_RD  = 8'h52;
  localparam logic [7:0] C_DBG = 8'h44;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_debug_mode;
  logic [31:0] o_wb_dbg_adr;
  logic [31:0] o_wb_dbg_dat;
  logic [3:0]  o_wb_dbg_sel;
  logic        o_wb_dbg_we;
  logic        o_wb_dbg_stb;
  logic [31:0] i_wb_dbg_rdt;
  logic        i_wb_dbg_ack;

  always #5 clk = ~clk;

  subservient_dbg_host #(.TIMEOUT(15)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_debug_mode (o_debug_mode),
    .o_wb_dbg_adr (o_wb_dbg_adr),
    .o_wb_dbg_dat (o_wb_dbg_dat),
    .o_wb_dbg_sel (o_wb_dbg_sel),
    .o_wb_dbg_we  (o_wb_dbg_we),
    .o_wb_dbg_stb (o_wb_dbg_stb),
    .i_wb_dbg_rdt (i_wb_dbg_rdt),
    .i_wb_dbg_ack (i_wb_dbg_ack)
  );

  int asserts_n = 0;
  int fails_n   = 0;

  // ---------------- reference model state ----------------
  logic                      m_dbg = 1'b0;
  logic [31:0]               m_mem [logic [31:0]];
  logic [7:0]                exp_q [$];
  bit                        exp_has_txn;
  logic                      exp_we;
  logic [31:0]               exp_adr, exp_dat;

  // ---------------- Wishbone slave ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        stable;
  } txn_t;

  txn_t        txn_q [$];
  logic [31:0] slv_mem [logic [31:0]];
  bit          slv_en  = 1'b1;
  int          slv_lat = 0;
  int          slv_cnt = 0;
  bit          slv_busy = 1'b0;
  logic [31:0] first_adr, first_dat;
  int          stb_cycles = 0;
  bit          tx_toggle = 1'b0;

  function automatic logic [31:0] def_rd(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  initial begin
    i_wb_dbg_ack = 1'b0;
    i_wb_dbg_rdt = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    if (o_wb_dbg_stb) stb_cycles++;
    if (i_wb_dbg_ack) begin
      i_wb_dbg_ack = 1'b0;
      i_wb_dbg_rdt = $urandom;
      slv_cnt = 0;
    end else if (o_wb_dbg_stb && slv_en) begin
      if (!slv_busy) begin
        slv_busy  = 1'b1;
        first_adr = o_wb_dbg_adr;
        first_dat = o_wb_dbg_dat;
      end
      if (slv_cnt >= slv_lat) begin
        i_wb_dbg_ack = 1'b1;
        i_wb_dbg_rdt = slv_mem.exists(o_wb_dbg_adr) ? slv_mem[o_wb_dbg_adr] : def_rd(o_wb_dbg_adr);
        if (o_wb_dbg_we) slv_mem[o_wb_dbg_adr] = o_wb_dbg_dat;
        txn_q.push_back('{o_wb_dbg_we, o_wb_dbg_adr, o_wb_dbg_dat, o_wb_dbg_sel,
                          (o_wb_dbg_adr == first_adr) && (o_wb_dbg_dat == first_dat)});
        slv_busy = 1'b0;
        slv_cnt  = 0;
      end else begin
        slv_cnt++;
      end
    end else begin
      i_wb_dbg_rdt = $urandom;
      if (!o_wb_dbg_stb) begin
        slv_cnt  = 0;
        slv_busy = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts_n++;
    assert (obs === exp) else begin
      fails_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (o_rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
    check("rx_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [7:0] arg);
    send_byte(op);
    if (op == C_WR || op == C_RD) begin
      for (int i = 0; i < 4; i++) send_byte(adr[i*8 +: 8]);
    end
    if (op == C_WR) begin
      for (int i = 0; i < 4; i++) send_byte(dat[i*8 +: 8]);
    end
    if (op == C_DBG) send_byte(arg);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      i_tx_ready = tx_toggle ? ~i_tx_ready : 1'b1;
      if (o_tx_valid && i_tx_ready) begin
        b  = o_tx_data;
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    i_tx_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_rx_ready && !o_tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, {31'd0, ok}, 32'd1);
  endtask

  // Command-level model: expected reply bytes and bus transaction.
  task automatic model_cmd(input logic [7:0] op, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [7:0] arg);
    logic [31:0] v;
    exp_q.delete();
    exp_has_txn = 1'b0;
    exp_we  = 1'b0;
    exp_adr = adr;
    exp_dat = dat;
    if (op == C_DBG) begin
      m_dbg = arg[0];
      exp_q.push_back(8'h06);
    end else if ((op == C_WR || op == C_RD) && !m_dbg) begin
      exp_q.push_back(8'h15);
    end else if (op == C_WR) begin
      m_mem[adr]  = dat;
      exp_has_txn = 1'b1;
      exp_we      = 1'b1;
      exp_q.push_back(8'h06);
    end else if (op == C_RD) begin
      v = m_mem.exists(adr) ? m_mem[adr] : def_rd(adr);
      exp_has_txn = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(v[i*8 +: 8]);
    end else begin
      exp_q.push_back(8'h15);
    end
  endtask

  task automatic finish_cmd(input string tag);
    logic [7:0] b;
    logic       ok;
    txn_t       t;
    foreach (exp_q[i]) begin
      recv_byte(b, ok);
      check({tag, "_tx_ok"}, {31'd0, ok}, 32'd1);
      check({tag, "_tx_byte"}, {24'd0, b}, {24'd0, exp_q[i]});
    end
    wait_idle(tag);
    check({tag, "_dbg_mode"}, {31'd0, o_debug_mode}, {31'd0, m_dbg});
    check({tag, "_ntxn"}, txn_q.size(), exp_has_txn ? 32'd1 : 32'd0);
    if (exp_has_txn && txn_q.size() > 0) begin
      t = txn_q.pop_front();
      check({tag, "_we"}, {31'd0, t.we}, {31'd0, exp_we});
      check({tag, "_adr"}, t.adr, exp_adr);
      check({tag, "_sel"}, {28'd0, t.sel}, 32'hF);
      check({tag, "_stable"}, {31'd0, t.stable}, 32'd1);
      if (exp_we) check({tag, "_dat"}, t.dat, exp_dat);
    end
    txn_q.delete();
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [7:0] arg);
    model_cmd(op, adr, dat, arg);
    send_cmd(op, adr, dat, arg);
    finish_cmd(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          n0;
    int          ack_wait;
    logic [7:0]  op, arg;
    logic [31:0] adr, dat;
    int          pick;

    rst_n      = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_tx_ready = 1'b0;
    #1;
    check("rst_stb",      {31'd0, o_wb_dbg_stb}, 32'd0);
    check("rst_tx_valid", {31'd0, o_tx_valid},   32'd0);
    check("rst_rx_ready", {31'd0, o_rx_ready},   32'd0);
    check("rst_dbg",      {31'd0, o_debug_mode}, 32'd0);
    check("rst_adr",      o_wb_dbg_adr,          32'd0);
    check("rst_sel",      {28'd0, o_wb_dbg_sel}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. debug-mode control
    run_cmd("d_on",  C_DBG, 32'd0, 32'd0, 8'h01);
    run_cmd("d_off", C_DBG, 32'd0, 32'd0, 8'h00);

    // 2. write with bus timing checks
    run_cmd("d_on2", C_DBG, 32'd0, 32'd0, 8'h01);
    slv_lat = 3;
    model_cmd(C_WR, 32'h00000100, 32'hDEADBEEF, 8'h00);
    send_cmd(C_WR, 32'h00000100, 32'hDEADBEEF, 8'h00);
    @(negedge clk);
    check("w_stb_rise", {31'd0, o_wb_dbg_stb}, 32'd1);
    check("w_adr",      o_wb_dbg_adr, 32'h00000100);
    check("w_we",       {31'd0, o_wb_dbg_we}, 32'd1);
    check("w_sel",      {28'd0, o_wb_dbg_sel}, 32'hF);
    check("w_dat",      o_wb_dbg_dat, 32'hDEADBEEF);
    ack_wait = 0;
    for (int i = 0; i < 20; i++) begin
      if (i_wb_dbg_ack) break;
      @(negedge clk);
      ack_wait++;
    end
    check("w_ack_seen", {31'd0, i_wb_dbg_ack}, 32'd1);
    check("w_stb_hold", {31'd0, o_wb_dbg_stb}, 32'd1);
    @(negedge clk);
    check("w_stb_fall", {31'd0, o_wb_dbg_stb}, 32'd0);
    finish_cmd("w_main");

    // 3. read back with a throttled response stream
    slv_lat = 1;
    run_cmd("w_pat", C_WR, 32'h00000100, 32'h12345678, 8'h00);
    tx_toggle = 1'b1;
    run_cmd("r_pat", C_RD, 32'h00000100, 32'd0, 8'h00);
    tx_toggle = 1'b0;

    // 4. unknown opcode, then W while debug is off
    run_cmd("junk",     8'hA5, 32'd0, 32'd0, 8'h00);
    run_cmd("after_jk", C_DBG, 32'd0, 32'd0, 8'h00);
    n0 = stb_cycles;
    run_cmd("w_nodbg",  C_WR, 32'h00000200, 32'hCAFEF00D, 8'h00);
    check("w_nodbg_nostb", stb_cycles - n0, 32'd0);
    run_cmd("r_nodbg",  C_RD, 32'h00000100, 32'd0, 8'h00);

    // randomized command stream
    for (int k = 0; k < 40; k++) begin
      pick      = $urandom_range(0, 9);
      slv_lat   = $urandom_range(0, 4);
      tx_toggle = $urandom_range(0, 1);
      adr = ($urandom_range(0, 3) == 3) ? $urandom : 32'h100 + {$urandom_range(0, 2), 2'b00};
      dat = $urandom;
      arg = 8'($urandom);
      arg[0] = ($urandom_range(0, 3) != 0);
      if (pick < 3)      op = C_WR;
      else if (pick < 6) op = C_RD;
      else if (pick < 8) op = C_DBG;
      else begin
        op = 8'($urandom);
        if (op == C_WR || op == C_RD || op == C_DBG) op = 8'hA5;
      end
      run_cmd("rand", op, adr, dat, arg);
    end
    tx_toggle = 1'b0;

    // 5. slave never acks
    run_cmd("d_on3", C_DBG, 32'd0, 32'd0, 8'h01);
    slv_en = 1'b0;
    n0 = stb_cycles;
    send_cmd(C_RD, 32'h00000300, 32'd0, 8'h00);
`ifdef SUBSERVIENT_DBG_TIMEOUT_EN
    exp_q.delete();
    exp_q.push_back(8'hEE);
    exp_has_txn = 1'b0;
    finish_cmd("tmo");
    check("tmo_stb_cycles", stb_cycles - n0, 32'd15);
    send_cmd(C_RD, 32'h00000304, 32'd0, 8'h00);
    repeat (3) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    check("notmo_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    check("notmo_rx_ready", {31'd0, o_rx_ready}, 32'd0);
`endif
    check("bus_stb_pre_rst", {31'd0, o_wb_dbg_stb}, 32'd1);

    // 6. reset during BUS
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stb",      {31'd0, o_wb_dbg_stb}, 32'd0);
    check("rst_mid_tx_valid", {31'd0, o_tx_valid},   32'd0);
    check("rst_mid_dbg",      {31'd0, o_debug_mode}, 32'd0);
    m_dbg = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    slv_en = 1'b1;
    txn_q.delete();
    run_cmd("post_rst_d", C_DBG, 32'd0, 32'd0, 8'h01);
    slv_lat = 2;
    run_cmd("post_rst_r", C_RD, 32'h00000100, 32'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
    $finish;
  end

endmodule
